// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Used by rr_arb2 and alu_arbiter.
package alu_arb_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } alu_arb_state_t;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_AND    = 3'b000;
    localparam alu_op_t ALU_OR     = 3'b001;
    localparam alu_op_t ALU_ADD    = 3'b010;
    localparam alu_op_t ALU_PMATCH = 3'b011;
    localparam alu_op_t ALU_SUB    = 3'b110;
    localparam alu_op_t ALU_SLT    = 3'b111;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way arbiter: round-robin on last_grant, or fixed priority to
// requester 0 when FIXED_PRIO is non-zero.
module rr_arb2 #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        case (req)
            2'b01: begin
                grant    = 2'b01;
                grant_id = 1'b0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                // On a tie, requester 0 wins unless it was the last one served.
                if ((FIXED_PRIO != 0) || last_grant) begin
                    grant    = 2'b01;
                    grant_id = 1'b0;
                end else begin
                    grant    = 2'b10;
                    grant_id = 1'b1;
                end
            end
            default: begin
                grant    = 2'b00;
                grant_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: arbitrate, execute from registered
// operands, return a tagged response. Define ALU_ARBITER_PERF_EN for grant counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_f,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_f,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_f,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_zero,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_zero
`ifdef ALU_ARBITER_PERF_EN
    ,
    output logic [15:0]       perf_grant0,
    output logic [15:0]       perf_grant1
`endif
);

    alu_arb_state_t    state_q, state_d;
    logic [DATA_W-1:0] op_a_q, op_b_q;
    logic [2:0]        op_f_q;
    logic              op_id_q;
    logic              last_grant_q;

    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_y_q;
    logic              rsp_zero_q;

    logic [1:0]        grant;
    logic              grant_id;
    logic              take;

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .req       ({req1_valid, req0_valid}),
        .last_grant(last_grant_q),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset && (grant != 2'b00)) begin
                    take    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                // Return to IDLE only; a new grant waits for the following cycle.
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready = take & grant[0];
    assign req1_ready = take & grant[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_f_q       <= '0;
            op_id_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_y_q      <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                op_a_q       <= grant_id ? req1_a : req0_a;
                op_b_q       <= grant_id ? req1_b : req0_b;
                op_f_q       <= grant_id ? req1_f : req0_f;
                op_id_q      <= grant_id;
                last_grant_q <= grant_id;
            end
            if (state_q == EXEC) begin
                rsp_y_q     <= alu_y;
                rsp_zero_q  <= alu_zero;
                rsp_id_q    <= op_id_q;
                rsp_valid_q <= 1'b1;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;
    assign alu_f     = op_f_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_zero  = rsp_zero_q;

`ifdef ALU_ARBITER_PERF_EN
    logic [15:0] perf_grant0_q, perf_grant1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grant0_q <= '0;
            perf_grant1_q <= '0;
        end else begin
            if (req0_ready && (perf_grant0_q != 16'hFFFF)) begin
                perf_grant0_q <= perf_grant0_q + 16'd1;
            end
            if (req1_ready && (perf_grant1_q != 16'hFFFF)) begin
                perf_grant1_q <= perf_grant1_q + 16'd1;
            end
        end
    end

    assign perf_grant0 = perf_grant0_q;
    assign perf_grant1 = perf_grant1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance, each
// driving a small behavioural ALU. Checks perf counters when ALU_ARBITER_PERF_EN is set.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Round-robin instance
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [2:0]  r0_f, r1_f;
    logic [31:0] a_a, a_b, a_y;
    logic [2:0]  a_f;
    logic        a_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_y;

    // Fixed-priority instance
    logic        f0_valid, f0_ready, f1_valid, f1_ready;
    logic [31:0] f0_a, f0_b, f1_a, f1_b;
    logic [2:0]  f0_f, f1_f;
    logic [31:0] fa_a, fa_b, fa_y;
    logic [2:0]  fa_f;
    logic        fa_zero;
    logic        f_rsp_valid, f_rsp_ready, f_rsp_id, f_rsp_zero;
    logic [31:0] f_rsp_y;

`ifdef ALU_ARBITER_PERF_EN
    logic [15:0] perf0, perf1, fperf0, fperf1;
`endif

    // Behavioural stand-in for the external ALU
    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f);
        logic [31:0] y;
        case (f)
            3'b000:  y = a & b;
            3'b001:  y = a | b;
            3'b010:  y = a + b;
            3'b011:  y = {31'b0, a == b};
            3'b100:  y = a ^ b;
            3'b101:  y = ~(a | b);
            3'b110:  y = a - b;
            default: y = {31'b0, $signed(a) < $signed(b)};
        endcase
        return {y == 32'd0, y};
    endfunction

    assign {a_zero, a_y}   = alu_model(a_a, a_b, a_f);
    assign {fa_zero, fa_y} = alu_model(fa_a, fa_b, fa_f);

    alu_arbiter #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .req0_valid(r0_valid), .req0_ready(r0_ready),
        .req0_a(r0_a), .req0_b(r0_b), .req0_f(r0_f),
        .req1_valid(r1_valid), .req1_ready(r1_ready),
        .req1_a(r1_a), .req1_b(r1_b), .req1_f(r1_f),
        .alu_a(a_a), .alu_b(a_b), .alu_f(a_f), .alu_y(a_y), .alu_zero(a_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_zero(rsp_zero)
`ifdef ALU_ARBITER_PERF_EN
        , .perf_grant0(perf0), .perf_grant1(perf1)
`endif
    );

    alu_arbiter #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset),
        .req0_valid(f0_valid), .req0_ready(f0_ready),
        .req0_a(f0_a), .req0_b(f0_b), .req0_f(f0_f),
        .req1_valid(f1_valid), .req1_ready(f1_ready),
        .req1_a(f1_a), .req1_b(f1_b), .req1_f(f1_f),
        .alu_a(fa_a), .alu_b(fa_b), .alu_f(fa_f), .alu_y(fa_y), .alu_zero(fa_zero),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id),
        .rsp_y(f_rsp_y), .rsp_zero(f_rsp_zero)
`ifdef ALU_ARBITER_PERF_EN
        , .perf_grant0(fperf0), .perf_grant1(fperf1)
`endif
    );

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] y;
        logic        z;
    } vec_t;

    vec_t vecs[9];

    // Counts any cycle where requester 1 is offered while requester 0 still waits.
    int f1_steal = 0;
    always @(negedge clk) begin
        if (!reset && f0_valid && f1_ready) f1_steal++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [31:0] ey, input logic ez,
                         input string nm);
        bit got;
        @(negedge clk);
        if (id) begin
            r1_valid = 1'b1; r1_a = a; r1_b = b; r1_f = f;
        end else begin
            r0_valid = 1'b1; r0_a = a; r0_b = b; r0_f = f;
        end
        #1;
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if ((id ? r1_ready : r0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk({nm, " grant"}, {31'b0, got}, 32'd1);
        if (!got) begin
            r0_valid = 1'b0;
            r1_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
        chk({nm, " exec valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({nm, " alu_a"}, a_a, a);
        chk({nm, " alu_b"}, a_b, b);
        chk({nm, " alu_f"}, {29'b0, a_f}, {29'b0, f});
        @(negedge clk);
        chk({nm, " rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({nm, " rsp_id"}, {31'b0, rsp_id}, {31'b0, id});
        chk({nm, " rsp_y"}, rsp_y, ey);
        chk({nm, " rsp_zero"}, {31'b0, rsp_zero}, {31'b0, ez});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, " rsp drop"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'd7,         32'd5,         ALU_ADD,    32'd12,        1'b0};
        vecs[1] = '{1'b1, 32'hF0F0F0F0,  32'h0FF00FF0,  ALU_AND,    32'h00F000F0,  1'b0};
        vecs[2] = '{1'b0, 32'hF0000000,  32'h0000000F,  ALU_OR,     32'hF000000F,  1'b0};
        vecs[3] = '{1'b1, 32'hFFFFFFFF,  32'd1,         ALU_SLT,    32'd1,         1'b0};
        vecs[4] = '{1'b0, 32'd5,         32'd3,         ALU_SLT,    32'd0,         1'b1};
        vecs[5] = '{1'b1, 32'hFFFFFFFF,  32'd1,         ALU_ADD,    32'd0,         1'b1};
        vecs[6] = '{1'b0, 32'd3,         32'd5,         ALU_SUB,    32'hFFFFFFFE,  1'b0};
        vecs[7] = '{1'b1, 32'h0000FF00,  32'h00000FF0,  3'b100,     32'h0000F0F0,  1'b0};
        vecs[8] = '{1'b0, 32'h12345678,  32'h12345678,  ALU_PMATCH, 32'd1,         1'b0};

        reset = 1'b1;
        rsp_ready = 1'b0; f_rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_a = 32'd7; r0_b = 32'd5; r0_f = ALU_ADD;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_f = '0;
        f0_valid = 1'b0; f0_a = '0; f0_b = '0; f0_f = '0;
        f1_valid = 1'b0; f1_a = '0; f1_b = '0; f1_f = '0;

        // Reset held two cycles with req0 pending
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst ready0", {31'b0, r0_ready}, 32'd0);
            chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("rst alu_a", a_a, 32'd0);
            chk("rst alu_b", a_b, 32'd0);
            chk("rst alu_f", {29'b0, a_f}, 32'd0);
        end
`ifdef ALU_ARBITER_PERF_EN
        chk("rst perf0", {16'b0, perf0}, 32'd0);
        chk("rst perf1", {16'b0, perf1}, 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("post-rst ready0", {31'b0, r0_ready}, 32'd1);
        r0_valid = 1'b0;

        // Table of single operations
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].y, vecs[i].z,
                  $sformatf("vec%0d", i));
        end

        // Zero flag with backpressure
        @(negedge clk);
        r1_valid = 1'b1; r1_a = 32'd9; r1_b = 32'd9; r1_f = ALU_SUB;
        #1;
        chk("bp grant", {31'b0, r1_ready}, 32'd1);
        @(negedge clk);
        r1_valid = 1'b0;
        chk("bp exec valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("bp hold valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp hold y", rsp_y, 32'd0);
            chk("bp hold zero", {31'b0, rsp_zero}, 32'd1);
            chk("bp hold id", {31'b0, rsp_id}, 32'd1);
            if (i < 3) @(negedge clk);
        end
        rsp_ready = 1'b1;
        r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd2; r0_f = ALU_ADD;
        #1;
        chk("bp no bypass", {31'b0, r0_ready}, 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp released", {31'b0, rsp_valid}, 32'd0);
        #1;
        chk("bp idle after", {31'b0, r0_ready}, 32'd1);
        @(negedge clk);
        r0_valid = 1'b0;
        @(negedge clk);
        chk("bp follow y", rsp_y, 32'd3);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Round-robin with both requesters always valid
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        r0_valid = 1'b1; r0_a = 32'hFFFFFFFF; r0_b = 32'd1; r0_f = ALU_SLT;
        r1_valid = 1'b1; r1_a = 32'd50; r1_b = 32'd100; r1_f = ALU_ADD;
        for (int k = 0; k < 6; k++) begin
            logic exp_id;
            bit got;
            exp_id = k[0];
            #1;
            got = 1'b0;
            for (int n = 0; n < 6; n++) begin
                if (r0_ready || r1_ready) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
                #1;
            end
            chk($sformatf("rr%0d grant", k), {30'b0, r1_ready, r0_ready},
                exp_id ? 32'd2 : 32'd1);
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("rr%0d valid", k), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("rr%0d id", k), {31'b0, rsp_id}, {31'b0, exp_id});
            chk($sformatf("rr%0d y", k), rsp_y, exp_id ? 32'd150 : 32'd1);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;

        // Reset while an operation is in EXEC
        @(negedge clk);
        r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd1; r0_f = ALU_ADD;
        #1;
        chk("mid grant", {31'b0, r0_ready}, 32'd1);
        @(negedge clk);
        r0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid rsp_valid", {31'b0, rsp_valid}, 32'd0);
        r0_valid = 1'b1;
        #1;
        chk("mid idle", {31'b0, r0_ready}, 32'd1);
        r0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid no rsp", {31'b0, rsp_valid}, 32'd0);
        end

        // Three grants to req0, two to req1
        do_op(vecs[0].id, vecs[0].a, vecs[0].b, vecs[0].f, vecs[0].y, vecs[0].z, "perf a");
        do_op(vecs[1].id, vecs[1].a, vecs[1].b, vecs[1].f, vecs[1].y, vecs[1].z, "perf b");
        do_op(vecs[2].id, vecs[2].a, vecs[2].b, vecs[2].f, vecs[2].y, vecs[2].z, "perf c");
        do_op(vecs[3].id, vecs[3].a, vecs[3].b, vecs[3].f, vecs[3].y, vecs[3].z, "perf d");
        do_op(vecs[4].id, vecs[4].a, vecs[4].b, vecs[4].f, vecs[4].y, vecs[4].z, "perf e");
`ifdef ALU_ARBITER_PERF_EN
        chk("perf0 count", {16'b0, perf0}, 32'd3);
        chk("perf1 count", {16'b0, perf1}, 32'd2);
`endif

        // Fixed priority: requester 0 wins every tie
        @(negedge clk);
        f0_valid = 1'b1; f0_a = 32'd20; f0_b = 32'd22; f0_f = ALU_ADD;
        f1_valid = 1'b1; f1_a = 32'd1;  f1_b = 32'd1;  f1_f = ALU_ADD;
        for (int k = 0; k < 4; k++) begin
            #1;
            for (int n = 0; n < 6; n++) begin
                if (f0_ready || f1_ready) break;
                @(negedge clk);
                #1;
            end
            chk($sformatf("fp%0d grant0", k), {31'b0, f0_ready}, 32'd1);
            chk($sformatf("fp%0d grant1", k), {31'b0, f1_ready}, 32'd0);
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("fp%0d id", k), {31'b0, f_rsp_id}, 32'd0);
            chk($sformatf("fp%0d y", k), f_rsp_y, 32'd42);
            f_rsp_ready = 1'b1;
            @(negedge clk);
            f_rsp_ready = 1'b0;
        end
        chk("fp no steal", f1_steal, 32'd0);
        f0_valid = 1'b0;
        #1;
        chk("fp req1 after drop", {31'b0, f1_ready}, 32'd1);
        f1_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
